// File: rtl/id_ix_issue_ctrl_pkg.sv
// Shared types and constants for the ID/IX issue and interlock controller.
package id_ix_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       is_load;
  } slot_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam int unsigned NUM_SLOTS = 3;
  localparam int unsigned SLOT_IX   = 0;
  localparam int unsigned SLOT_MEM  = 1;
  localparam int unsigned SLOT_WB   = 2;

  // Slots are only ever filled by register-writing, non-r0 instructions,
  // so valid alone means "writing".
  function automatic logic slot_hit(slot_t s, logic live, logic [4:0] r);
    return live && s.valid && (s.dest == r);
  endfunction

endpackage

// File: rtl/id_ix_issue_ctrl_if.sv
// ID-stage request and issue-control response bundle around the ID/IX register.
interface id_ix_issue_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [4:0]       id_dest;
  logic             id_write_to_reg;
  logic             id_is_load;
  logic             ix_redirect;
  logic             stall;
  logic             bubble;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             squash_active;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] squash_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_write_to_reg, id_is_load, ix_redirect,
    input  stall, bubble, fwd_a_sel, fwd_b_sel, squash_active,
           stall_cnt, squash_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
           id_write_to_reg, id_is_load, ix_redirect,
    output stall, bubble, fwd_a_sel, fwd_b_sel, squash_active,
           stall_cnt, squash_cnt
  );
endinterface

// File: rtl/id_ix_issue_ctrl_sat_counter.sv
// Saturating event counter, updated on the pipeline capture (falling) edge.
module issue_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/id_ix_issue_ctrl.sv
// Issue/interlock controller: load-use stall, redirect squash and registered
// forwarding selects for the instruction crossing ID/IX.
module id_ix_issue_ctrl
  import id_ix_issue_ctrl_pkg::*;
#(
  parameter int unsigned SQUASH_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input logic              clk,
  input logic              rst,
  id_ix_issue_ctrl_if.slave bus
);

  localparam logic [1:0] SQ_LOAD = 2'(SQUASH_CYCLES);

  slot_t      sb_q [NUM_SLOTS];
  slot_t      sb_d [NUM_SLOTS];
  logic [1:0] squash_q, squash_d;
  fwd_sel_e   fwd_a_q, fwd_a_d;
  fwd_sel_e   fwd_b_q, fwd_b_d;

  logic rs_live, rt_live;
  logic load_use, squash, bubble, stall_w, issue;

  function automatic fwd_sel_e pick_fwd(logic live, logic [4:0] r, slot_t ix, slot_t mem);
    if (slot_hit(ix, live, r))  return FWD_MEM;
    if (slot_hit(mem, live, r)) return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    rs_live  = bus.id_valid && bus.id_uses_rs && (bus.id_rs != REG_ZERO);
    rt_live  = bus.id_valid && bus.id_uses_rt && (bus.id_rt != REG_ZERO);
    load_use = sb_q[SLOT_IX].is_load &&
               (slot_hit(sb_q[SLOT_IX], rs_live, bus.id_rs) ||
                slot_hit(sb_q[SLOT_IX], rt_live, bus.id_rt));
    // A redirect makes the ID instruction wrong-path, so it wins over load-use.
    squash   = bus.ix_redirect || (squash_q != '0);
    bubble   = squash || load_use;
    stall_w  = load_use && !squash;
    issue    = bus.id_valid && !bubble;

    sb_d[SLOT_IX] = '0;
    if (issue && bus.id_write_to_reg && (bus.id_dest != REG_ZERO)) begin
      sb_d[SLOT_IX].valid   = 1'b1;
      sb_d[SLOT_IX].dest    = bus.id_dest;
      sb_d[SLOT_IX].is_load = bus.id_is_load;
    end
    for (int unsigned i = 1; i < NUM_SLOTS; i++) sb_d[i] = sb_q[i-1];

    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!bubble) begin
      fwd_a_d = pick_fwd(rs_live, bus.id_rs, sb_q[SLOT_IX], sb_q[SLOT_MEM]);
      fwd_b_d = pick_fwd(rt_live, bus.id_rt, sb_q[SLOT_IX], sb_q[SLOT_MEM]);
    end

    squash_d = squash_q;
    if (bus.ix_redirect)      squash_d = SQ_LOAD;
    else if (squash_q != '0)  squash_d = squash_q - 2'd1;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) sb_q[i] <= '0;
      squash_q <= '0;
      fwd_a_q  <= FWD_RF;
      fwd_b_q  <= FWD_RF;
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) sb_q[i] <= sb_d[i];
      squash_q <= squash_d;
      fwd_a_q  <= fwd_a_d;
      fwd_b_q  <= fwd_b_d;
    end
  end

  assign bus.stall         = stall_w;
  assign bus.bubble        = bubble;
  assign bus.fwd_a_sel     = fwd_a_q;
  assign bus.fwd_b_sel     = fwd_b_q;
  assign bus.squash_active = (squash_q != '0);

  issue_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_w),
    .count (bus.stall_cnt)
  );

  issue_sat_counter #(.CNT_W(CNT_W)) u_squash_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (squash && bus.id_valid),
    .count (bus.squash_cnt)
  );

endmodule

// File: tb/tb_id_ix_issue_ctrl.sv
// Directed bench for id_ix_issue_ctrl; a second narrow instance checks saturation.
module tb_id_ix_issue_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  id_ix_issue_ctrl_if #(.CNT_W(16)) bus ();
  id_ix_issue_ctrl_if #(.CNT_W(2))  bus2 ();

  id_ix_issue_ctrl #(.SQUASH_CYCLES(1), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Redirect held high forever with SQUASH_CYCLES=0: counter saturates, squash never lingers.
  id_ix_issue_ctrl #(.SQUASH_CYCLES(0), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic put(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic [4:0] dest,
                     input logic wr, input logic ld, input logic redir);
    bus.id_valid        = v;
    bus.id_rs           = rs;
    bus.id_rt           = rt;
    bus.id_uses_rs      = urs;
    bus.id_uses_rt      = urt;
    bus.id_dest         = dest;
    bus.id_write_to_reg = wr;
    bus.id_is_load      = ld;
    bus.ix_redirect     = redir;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus2.id_valid = 1'b1; bus2.id_rs = 5'd0; bus2.id_rt = 5'd0;
    bus2.id_uses_rs = 1'b0; bus2.id_uses_rt = 1'b0; bus2.id_dest = 5'd0;
    bus2.id_write_to_reg = 1'b0; bus2.id_is_load = 1'b0; bus2.ix_redirect = 1'b1;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #11;
    check("rst_fwd_a", bus.fwd_a_sel, 0);
    check("rst_fwd_b", bus.fwd_b_sel, 0);
    check("rst_sq_act", bus.squash_active, 0);
    check("rst_stall_cnt", bus.stall_cnt, 0);
    check("rst_squash_cnt", bus.squash_cnt, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_bubble", bus.bubble, 0);
    check("rst_sat_cnt", bus2.squash_cnt, 0);
    rst = 1'b0;
    tick();

    // add r3<-r1+r2 ; sub r4<-r3-r5
    put(1, 1, 2, 1, 1, 3, 1, 0, 0);
    check("add_stall", bus.stall, 0);
    check("add_bubble", bus.bubble, 0);
    tick();
    check("add_fwd_a", bus.fwd_a_sel, 0);
    put(1, 3, 5, 1, 1, 4, 1, 0, 0);
    check("sub_stall", bus.stall, 0);
    tick();
    check("sub_fwd_a", bus.fwd_a_sel, 1);
    check("sub_fwd_b", bus.fwd_b_sel, 0);

    // lw r8 ; add r9<-r8+r8 (one-cycle load-use)
    put(1, 1, 0, 1, 0, 8, 1, 1, 0);
    check("lw_stall", bus.stall, 0);
    tick();
    put(1, 8, 8, 1, 1, 9, 1, 0, 0);
    check("lu_stall", bus.stall, 1);
    check("lu_bubble", bus.bubble, 1);
    tick();
    check("lu_fwd_a", bus.fwd_a_sel, 0);
    check("lu_stall_cnt", bus.stall_cnt, 1);
    check("retry_stall", bus.stall, 0);
    check("retry_bubble", bus.bubble, 0);
    tick();
    check("retry_fwd_a", bus.fwd_a_sel, 2);
    check("retry_fwd_b", bus.fwd_b_sel, 2);

    // lw r8 ; independent ; add r13<-r8+r0
    put(1, 1, 0, 1, 0, 8, 1, 1, 0);
    tick();
    put(1, 11, 12, 1, 1, 10, 1, 0, 0);
    check("indep_stall", bus.stall, 0);
    tick();
    put(1, 8, 0, 1, 1, 13, 1, 0, 0);
    check("gap_stall", bus.stall, 0);
    tick();
    check("gap_fwd_a", bus.fwd_a_sel, 2);
    check("gap_fwd_b", bus.fwd_b_sel, 0);

    // writes to r0 (ALU and load) then reader of r0
    put(1, 1, 2, 1, 1, 0, 1, 0, 0);
    tick();
    put(1, 1, 0, 1, 0, 0, 1, 1, 0);
    tick();
    put(1, 0, 0, 1, 1, 5, 1, 0, 0);
    check("r0_stall", bus.stall, 0);
    tick();
    check("r0_fwd_a", bus.fwd_a_sel, 0);
    check("r0_fwd_b", bus.fwd_b_sel, 0);
    check("r0_squash_cnt", bus.squash_cnt, 0);

    // redirect pulse, SQUASH_CYCLES=1
    put(1, 1, 2, 1, 1, 14, 1, 0, 1);
    check("redir_bubble", bus.bubble, 1);
    check("redir_stall", bus.stall, 0);
    check("redir_sq_act0", bus.squash_active, 0);
    tick();
    check("redir_sq_act1", bus.squash_active, 1);
    check("redir_squash_cnt1", bus.squash_cnt, 1);
    put(1, 1, 2, 1, 1, 14, 1, 0, 0);
    check("sq2_bubble", bus.bubble, 1);
    check("sq2_stall", bus.stall, 0);
    tick();
    check("sq2_sq_act", bus.squash_active, 0);
    check("sq2_squash_cnt", bus.squash_cnt, 2);
    check("post_bubble", bus.bubble, 0);
    tick();
    check("post_squash_cnt", bus.squash_cnt, 2);

    // redirect coinciding with load-use
    put(1, 1, 0, 1, 0, 8, 1, 1, 0);
    tick();
    put(1, 8, 8, 1, 1, 9, 1, 0, 1);
    check("rl_stall", bus.stall, 0);
    check("rl_bubble", bus.bubble, 1);
    tick();
    check("rl_stall_cnt", bus.stall_cnt, 1);
    check("rl_squash_cnt", bus.squash_cnt, 3);
    check("rl_sq_act", bus.squash_active, 1);
    put(1, 8, 8, 1, 1, 9, 1, 0, 0);
    check("rl2_bubble", bus.bubble, 1);
    tick();
    check("rl2_squash_cnt", bus.squash_cnt, 4);

    // asynchronous reset between edges with a load in ix
    put(1, 1, 0, 1, 0, 8, 1, 1, 0);
    tick();
    put(1, 8, 8, 1, 1, 9, 1, 0, 0);
    check("ar_pre_stall", bus.stall, 1);
    #1 rst = 1'b1;
    #1;
    check("ar_stall", bus.stall, 0);
    check("ar_bubble", bus.bubble, 0);
    check("ar_stall_cnt", bus.stall_cnt, 0);
    check("ar_squash_cnt", bus.squash_cnt, 0);
    check("ar_sat_cnt", bus2.squash_cnt, 0);
    #1 rst = 1'b0;
    tick();
    check("ar_fwd_a", bus.fwd_a_sel, 0);
    check("ar_fwd_b", bus.fwd_b_sel, 0);
    check("ar_post_stall_cnt", bus.stall_cnt, 0);

    // narrow instance: 4 redirect edges since reset release, 2-bit counter held at 3
    put(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    tick();
    check("sat_squash_cnt", bus2.squash_cnt, 3);
    check("sat_sq_act", bus2.squash_active, 0);
    check("sat_stall_cnt", bus2.stall_cnt, 0);
    check("sat_bubble", bus2.bubble, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
